// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: state encoding, default widths, timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_wb_stage_pkg;

  localparam int ADDR_W_DEF  = 22;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds req/wr/addr/wdata stable until a one-cycle ack.
interface mem_wb_stage_if #(
  parameter int ADDR_W = mem_wb_stage_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_wb_stage_pkg::DATA_W_DEF
);

  logic              dmem_req;
  logic              dmem_wr;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_wb_select.sv
// Write-back result mux: sprite data beats memory data beats ALU result.
// Latency: combinational.
// Backpressure: none.
module mem_wb_select #(
  parameter int DATA_W = 32
) (
  input  logic              sprite_sel,
  input  logic              mem_sel,
  input  logic [DATA_W-1:0] sprite_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] result
);

  // Priority select of the value headed for the register file.
  always_comb begin
    result = alu_data;
    if (sprite_sel)   result = sprite_data;
    else if (mem_sel) result = mem_data;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: launches data-memory accesses and registers the MEM/WB write-back outputs.
// Latency: 1 cycle for non-memory ops; memory ops hold MEM for 1 + wait cycles, then capture.
// Backpressure: mem_stall freezes upstream until ack or timeout; hlt freezes WB and new launches.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              flush,
  input  logic              MEM_re,
  input  logic              MEM_we,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_data,
  input  logic [DATA_W-1:0] MEM_ALU_result,
  input  logic [DATA_W-1:0] MEM_sprite_data,
  input  logic              MEM_mem_ALU_select,
  input  logic              MEM_sprite_ALU_select,
  input  logic              MEM_use_dst_reg,
  input  logic [4:0]        MEM_dst_reg,
  input  logic [ADDR_W-1:0] MEM_PC_out,
  mem_wb_stage_if.master    dmem,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              WB_we,
  output logic [4:0]        WB_dst_reg,
  output logic [DATA_W-1:0] WB_data,
  output logic [ADDR_W-1:0] WB_PC_out
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              flush_pend;
  logic              need;
  logic              timeout;
  logic              done;
  logic              squash;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wb_sel;

  assign need    = (MEM_re | MEM_we) & ~flush & ~hlt;
  assign timeout = (cnt == TO_VAL);
  assign done    = (state == BUSY) & (dmem.dmem_ack | timeout);
  // flush_pend is only ever set while BUSY, so in IDLE this reduces to flush.
  assign squash  = flush | flush_pend;
  // A timed-out access writes back zero instead of stale bus data.
  assign rd_data = ((state == BUSY) && dmem.dmem_ack) ? dmem.dmem_rdata : '0;

  mem_wb_select #(.DATA_W(DATA_W)) u_select (
    .sprite_sel  (MEM_sprite_ALU_select),
    .mem_sel     (MEM_mem_ALU_select),
    .sprite_data (MEM_sprite_data),
    .mem_data    (rd_data),
    .alu_data    (MEM_ALU_result),
    .result      (wb_sel)
  );

  // Stall while launching an access and while waiting for its ack.
  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE) mem_stall = need;
    else               mem_stall = ~dmem.dmem_ack & ~timeout;
  end

  // Access FSM, timeout counter and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      flush_pend      <= 1'b0;
      mem_err         <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_wr    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      WB_we           <= 1'b0;
      WB_dst_reg      <= '0;
      WB_data         <= '0;
      WB_PC_out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (need) begin
            state           <= BUSY;
            cnt             <= '0;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_wr    <= MEM_we;
            dmem.dmem_addr  <= MEM_addr;
            dmem.dmem_wdata <= MEM_data;
            WB_we           <= 1'b0;
          end else if (!hlt) begin
            WB_we      <= MEM_use_dst_reg & ~squash;
            WB_dst_reg <= MEM_dst_reg;
            WB_data    <= wb_sel;
            WB_PC_out  <= MEM_PC_out;
          end
        end
        BUSY: begin
          if (done) begin
            state         <= IDLE;
            dmem.dmem_req <= 1'b0;
            flush_pend    <= 1'b0;
            // Ack wins over a coincident timeout.
            mem_err       <= mem_err | ~dmem.dmem_ack;
            WB_we         <= MEM_use_dst_reg & ~squash;
            WB_dst_reg    <= MEM_dst_reg;
            WB_data       <= wb_sel;
            WB_PC_out     <= MEM_PC_out;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            flush_pend <= flush_pend | flush;
            WB_we      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: loads, stores, pass-through, flush, halt, timeout, reset.
// Latency: n/a.
// Backpressure: bench plays the pipeline, retiring the MEM instruction when mem_stall is low.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hlt;
  logic        flush;
  logic        MEM_re;
  logic        MEM_we;
  logic [21:0] MEM_addr;
  logic [31:0] MEM_data;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_sprite_data;
  logic        MEM_mem_ALU_select;
  logic        MEM_sprite_ALU_select;
  logic        MEM_use_dst_reg;
  logic [4:0]  MEM_dst_reg;
  logic [21:0] MEM_PC_out;
  logic        mem_stall;
  logic        mem_err;
  logic        WB_we;
  logic [4:0]  WB_dst_reg;
  logic [31:0] WB_data;
  logic [21:0] WB_PC_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage_if #(.ADDR_W(22), .DATA_W(32)) dmem_bus ();

  mem_wb_stage dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hlt                   (hlt),
    .flush                 (flush),
    .MEM_re                (MEM_re),
    .MEM_we                (MEM_we),
    .MEM_addr              (MEM_addr),
    .MEM_data              (MEM_data),
    .MEM_ALU_result        (MEM_ALU_result),
    .MEM_sprite_data       (MEM_sprite_data),
    .MEM_mem_ALU_select    (MEM_mem_ALU_select),
    .MEM_sprite_ALU_select (MEM_sprite_ALU_select),
    .MEM_use_dst_reg       (MEM_use_dst_reg),
    .MEM_dst_reg           (MEM_dst_reg),
    .MEM_PC_out            (MEM_PC_out),
    .dmem                  (dmem_bus),
    .mem_stall             (mem_stall),
    .mem_err               (mem_err),
    .WB_we                 (WB_we),
    .WB_dst_reg            (WB_dst_reg),
    .WB_data               (WB_data),
    .WB_PC_out             (WB_PC_out)
  );

  always #5 clk = ~clk;

  task automatic nop();
    hlt = 0; flush = 0; MEM_re = 0; MEM_we = 0;
    MEM_addr = '0; MEM_data = '0; MEM_ALU_result = '0; MEM_sprite_data = '0;
    MEM_mem_ALU_select = 0; MEM_sprite_ALU_select = 0;
    MEM_use_dst_reg = 0; MEM_dst_reg = '0; MEM_PC_out = '0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    nop();
    step(); step();
    @(negedge clk);
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem_bus.dmem_req); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    n_checks++; if ({mem_err, WB_we, WB_dst_reg, WB_data, WB_PC_out} !== '0) begin n_fail++; $display("FAIL reset_wb: got err=%b we=%b dst=%0d data=%h pc=%h want all 0", mem_err, WB_we, WB_dst_reg, WB_data, WB_PC_out); end
    n_checks++; if ({dmem_bus.dmem_wr, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== '0) begin n_fail++; $display("FAIL reset_bus: got wr=%b addr=%h wdata=%h want 0", dmem_bus.dmem_wr, dmem_bus.dmem_addr, dmem_bus.dmem_wdata); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_load();
    int  stall_cnt = 0;
    int  wb_cnt = 0;
    logic st;
    nop();
    MEM_re = 1; MEM_addr = 22'h000010; MEM_mem_ALU_select = 1; MEM_use_dst_reg = 1;
    MEM_dst_reg = 5; MEM_PC_out = 22'h000100; MEM_ALU_result = 32'h11111111;
    for (int c = 0; c < 8; c++) begin
      dmem_bus.dmem_ack   = (c == 4);
      dmem_bus.dmem_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_wr !== 1'b0) begin n_fail++; $display("FAIL load_req: got req=%b wr=%b want req=1 wr=0", dmem_bus.dmem_req, dmem_bus.dmem_wr); end
        n_checks++; if (dmem_bus.dmem_addr !== 22'h000010) begin n_fail++; $display("FAIL load_addr: got %h want 000010", dmem_bus.dmem_addr); end
      end
      if (mem_stall) stall_cnt++;
      if (WB_we) begin
        wb_cnt++;
        n_checks++; if (WB_data !== 32'hDEADBEEF || WB_dst_reg !== 5'd5 || WB_PC_out !== 22'h000100) begin n_fail++; $display("FAIL load_wb: got data=%h dst=%0d pc=%h want deadbeef 5 000100", WB_data, WB_dst_reg, WB_PC_out); end
      end
      st = mem_stall;
      step();
      if (!st) nop();
    end
    n_checks++; if (stall_cnt !== 4) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
    n_checks++; if (wb_cnt !== 1) begin n_fail++; $display("FAIL load_wb_count: got %0d want 1", wb_cnt); end
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop: got %b want 0", dmem_bus.dmem_req); end
  endtask

  task automatic test_store();
    int  stall_cnt = 0;
    int  wb_cnt = 0;
    logic st;
    nop();
    MEM_we = 1; MEM_addr = 22'h0003FF; MEM_data = 32'h12345678; MEM_dst_reg = 2;
    for (int c = 0; c < 5; c++) begin
      dmem_bus.dmem_ack = (c == 1);
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_wr !== 1'b1) begin n_fail++; $display("FAIL store_req: got req=%b wr=%b want 1 1", dmem_bus.dmem_req, dmem_bus.dmem_wr); end
        n_checks++; if (dmem_bus.dmem_wdata !== 32'h12345678 || dmem_bus.dmem_addr !== 22'h0003FF) begin n_fail++; $display("FAIL store_bus: got wdata=%h addr=%h want 12345678 0003ff", dmem_bus.dmem_wdata, dmem_bus.dmem_addr); end
      end
      if (mem_stall) stall_cnt++;
      if (WB_we) wb_cnt++;
      st = mem_stall;
      step();
      if (!st) nop();
    end
    n_checks++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL store_stall_cycles: got %0d want 1", stall_cnt); end
    n_checks++; if (wb_cnt !== 0) begin n_fail++; $display("FAIL store_wb_count: got %0d want 0", wb_cnt); end
  endtask

  task automatic test_alu_sprite();
    nop();
    MEM_use_dst_reg = 1; MEM_dst_reg = 7; MEM_ALU_result = 32'h00000042; MEM_PC_out = 22'h000200;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
    step();
    MEM_sprite_ALU_select = 1; MEM_sprite_data = 32'hCAFE0000; MEM_ALU_result = 32'h00000043; MEM_dst_reg = 8;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL sprite_stall: got %b want 0", mem_stall); end
    n_checks++; if (WB_we !== 1'b1 || WB_data !== 32'h00000042 || WB_dst_reg !== 5'd7) begin n_fail++; $display("FAIL alu_wb: got we=%b data=%h dst=%0d want 1 00000042 7", WB_we, WB_data, WB_dst_reg); end
    step();
    nop();
    @(negedge clk);
    n_checks++; if (WB_we !== 1'b1 || WB_data !== 32'hCAFE0000 || WB_dst_reg !== 5'd8) begin n_fail++; $display("FAIL sprite_wb: got we=%b data=%h dst=%0d want 1 cafe0000 8", WB_we, WB_data, WB_dst_reg); end
    step();
  endtask

  task automatic test_flush();
    int stall_cnt = 0;
    int wb_cnt = 0;
    nop();
    MEM_re = 1; MEM_addr = 22'h000020; MEM_mem_ALU_select = 1; MEM_use_dst_reg = 1;
    MEM_dst_reg = 3; MEM_PC_out = 22'h000300;
    for (int c = 0; c < 4; c++) begin
      flush               = (c == 1);
      dmem_bus.dmem_ack   = (c == 3);
      dmem_bus.dmem_rdata = (c == 3) ? 32'h00000055 : 32'h0;
      @(negedge clk);
      if (c >= 1) begin
        n_checks++; if (dmem_bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL flush_req_held_c%0d: got %b want 1", c, dmem_bus.dmem_req); end
      end
      if (mem_stall) stall_cnt++;
      if (WB_we) wb_cnt++;
      step();
    end
    nop();
    MEM_use_dst_reg = 1; MEM_dst_reg = 9; MEM_ALU_result = 32'h00000077;
    @(negedge clk);
    n_checks++; if (stall_cnt !== 3) begin n_fail++; $display("FAIL flush_stall_cycles: got %0d want 3", stall_cnt); end
    n_checks++; if (WB_we !== 1'b0 || wb_cnt !== 0) begin n_fail++; $display("FAIL flush_wb_squash: got we=%b count=%0d want 0 0", WB_we, wb_cnt); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL flush_next_stall: got %b want 0", mem_stall); end
    step();
    nop();
    @(negedge clk);
    n_checks++; if (WB_we !== 1'b1 || WB_data !== 32'h00000077 || WB_dst_reg !== 5'd9) begin n_fail++; $display("FAIL flush_next_wb: got we=%b data=%h dst=%0d want 1 00000077 9", WB_we, WB_data, WB_dst_reg); end
    step();
  endtask

  task automatic test_hlt();
    nop();
    MEM_use_dst_reg = 1; MEM_dst_reg = 10; MEM_ALU_result = 32'h000000A1;
    step();
    hlt = 1; MEM_re = 1; MEM_dst_reg = 11; MEM_ALU_result = 32'h000000B2;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hlt_stall: got %b want 0", mem_stall); end
    step();
    @(negedge clk);
    n_checks++; if (WB_data !== 32'h000000A1 || WB_dst_reg !== 5'd10 || WB_we !== 1'b1) begin n_fail++; $display("FAIL hlt_hold: got data=%h dst=%0d we=%b want 000000a1 10 1", WB_data, WB_dst_reg, WB_we); end
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL hlt_no_launch: got req=%b want 0", dmem_bus.dmem_req); end
    hlt = 0; MEM_re = 0;
    step();
    @(negedge clk);
    n_checks++; if (WB_data !== 32'h000000B2 || WB_dst_reg !== 5'd11) begin n_fail++; $display("FAIL hlt_release: got data=%h dst=%0d want 000000b2 11", WB_data, WB_dst_reg); end
    nop();
    step();
  endtask

  task automatic test_timeout();
    int stall_cnt = 0;
    bit done = 0;
    nop();
    MEM_re = 1; MEM_addr = 22'h000040; MEM_mem_ALU_select = 1; MEM_use_dst_reg = 1;
    MEM_dst_reg = 4; MEM_ALU_result = 32'h00000099; MEM_PC_out = 22'h000400;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stall_cnt++;
      else begin
        done = 1;
        n_checks++; if (dmem_bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL timeout_req_held: got %b want 1", dmem_bus.dmem_req); end
      end
      step();
    end
    nop();
    MEM_use_dst_reg = 1; MEM_dst_reg = 6; MEM_ALU_result = 32'h00000066;
    @(negedge clk);
    n_checks++; if (stall_cnt !== 256) begin n_fail++; $display("FAIL timeout_stall_cycles: got %0d want 256", stall_cnt); end
    n_checks++; if (dmem_bus.dmem_req !== 1'b0 || mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_abort: got req=%b err=%b want 0 1", dmem_bus.dmem_req, mem_err); end
    n_checks++; if (WB_data !== 32'h0 || WB_we !== 1'b1 || WB_dst_reg !== 5'd4) begin n_fail++; $display("FAIL timeout_wb: got data=%h we=%b dst=%0d want 0 1 4", WB_data, WB_we, WB_dst_reg); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL timeout_resume_stall: got %b want 0", mem_stall); end
    step();
    nop();
    @(negedge clk);
    n_checks++; if (WB_data !== 32'h00000066 || mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got data=%h err=%b want 00000066 1", WB_data, mem_err); end
    step();
  endtask

  task automatic test_reset_busy();
    int wb_cnt = 0;
    nop();
    MEM_re = 1; MEM_addr = 22'h000080; MEM_mem_ALU_select = 1; MEM_use_dst_reg = 1; MEM_dst_reg = 12;
    step(); step();
    @(negedge clk);
    n_checks++; if (dmem_bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre_req: got %b want 1", dmem_bus.dmem_req); end
    nop();
    rst_n = 0;
    #1;
    n_checks++; if ({dmem_bus.dmem_req, dmem_bus.dmem_addr, mem_err, WB_we, WB_data, WB_dst_reg} !== '0) begin n_fail++; $display("FAIL rstbusy_clear: got req=%b addr=%h err=%b we=%b data=%h dst=%0d want all 0", dmem_bus.dmem_req, dmem_bus.dmem_addr, mem_err, WB_we, WB_data, WB_dst_reg); end
    step(); step();
    rst_n = 1;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'h00000BAD;
    @(negedge clk);
    if (WB_we) wb_cnt++;
    step();
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (WB_we) wb_cnt++;
      if (c == 0) begin
        n_checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_idle: got stall=%b req=%b want 0 0", mem_stall, dmem_bus.dmem_req); end
      end
      step();
    end
    n_checks++; if (wb_cnt !== 0 || WB_data !== 32'h0) begin n_fail++; $display("FAIL rstbusy_stray_ack: got writes=%0d data=%h want 0 0", wb_cnt, WB_data); end
  endtask

  initial begin
    dmem_bus.dmem_ack   = 0;
    dmem_bus.dmem_rdata = '0;
    test_reset();
    test_load();
    test_store();
    test_alu_sprite();
    test_flush();
    test_hlt();
    test_timeout();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
